rip_tournament_predictor: RTL and testbench
===========================================

RIP_TOURNAMENT_PREDICTOR -- requirements
Module: rip_tournament_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 10: index width; each table holds 2^IDX_W entries.
REQ-002 SHALL have parameter CTR_W, default 2: width of bimodal and gshare saturating counters, legal range 2..4.
REQ-003 SHALL have parameter GHR_W, default IDX_W: global history length, legal range 1..IDX_W.
REQ-004 SHALL have parameter PC_LSB, default 2: lowest PC bit used for indexing.
REQ-005 SHALL have parameter MODE, default 2: 0 = bimodal only, 1 = gshare only, 2 = tournament.
REQ-006 SHALL have ports: clk in 1, the single clock; rstn in 1, synchronous active-low reset.
REQ-007 SHALL have ports: req_valid in 1, prediction request; pc in 32, fetch PC.
REQ-008 SHALL have port ready out 1, which is high when table initialisation is complete.
REQ-009 SHALL have ports: pred_valid out 1; pred out 1, taken prediction.
REQ-010 SHALL have ports: pred_idx_b out IDX_W; pred_idx_g out IDX_W; pred_ctr_b out CTR_W; pred_ctr_g out CTR_W; pred_sel out 2, chooser counter.
REQ-011 SHALL have ports: update in 1, resolved-branch strobe; upd_idx_b, upd_idx_g in IDX_W; upd_ctr_b, upd_ctr_g in CTR_W; upd_sel in 2; actual in 1, resolved direction.

Function
REQ-012 SHALL form pc_idx = pc[PC_LSB+IDX_W-1:PC_LSB], bimodal index = pc_idx, and gshare index = pc_idx XOR zero-extended GHR.
REQ-013 SHALL hold three tables: bimodal (CTR_W bits), gshare (CTR_W bits) and chooser (2 bits), each 2^IDX_W deep, with one read port and one write port each, inferable as BRAM.
REQ-014 SHALL, on req_valid=1 with ready=1 in cycle t, assert pred_valid in cycle t+1 together with registered indices, read counters and pred; pred_valid SHALL be 0 in every other cycle.
REQ-015 SHALL treat a counter as taken iff its value >= 2^(CTR_W-1).
REQ-016 SHALL compute pred as follows: MODE 0 gives bimodal taken; MODE 1 gives gshare taken; MODE 2 gives gshare taken if pred_sel >= 2, else bimodal taken.
REQ-017 SHALL, on update=1 with ready=1, write upd_ctr_b+1 saturating at 2^CTR_W-1 (actual=1), or upd_ctr_b-1 saturating at 0 (actual=0), to bimodal[upd_idx_b]; the same rule SHALL apply to gshare[upd_idx_g] using upd_ctr_g.
REQ-018 SHALL, in MODE 2 only, update chooser[upd_idx_b] only when the bimodal and gshare taken-bits of the update counters differ: increment, saturating at 3, if gshare was correct; decrement, saturating at 0, if bimodal was correct.
REQ-019 SHALL, in MODE 0, write neither the gshare nor the chooser table; in MODE 1, write neither the bimodal nor the chooser table.
REQ-020 SHALL shift the GHR on update=1 with ready=1: GHR <= {GHR[GHR_W-2:0], actual}, or GHR <= actual when GHR_W=1; the GHR SHALL hold in all other cycles and SHALL stay 0 in MODE 0.
REQ-021 SHALL use the GHR value from before any same-cycle shift when forming the gshare index of a request.
REQ-022 SHALL give read-first behaviour on a same-cycle read and write to the same entry: the prediction returns the old value, and the write takes effect for later reads.
REQ-023 SHALL ignore update and req_valid while ready=0.

Reset
REQ-024 SHALL, while rstn=0, drive ready=0, pred_valid=0, pred=0, all pred_idx_*, pred_ctr_* and pred_sel to 0, and clear the GHR to 0.
REQ-025 SHALL implement states INIT and RUN: reset enters INIT with sweep address 0.
REQ-026 SHALL, in INIT, write one entry per cycle to every table: bimodal and gshare entries get 2^(CTR_W-1)-1 (weakly not-taken), chooser entries get 1 (weakly bimodal).
REQ-027 SHALL move from INIT to RUN after writing address 2^IDX_W-1, so ready rises exactly 2^IDX_W cycles after the first cycle with rstn=1.
REQ-028 SHALL restart the sweep from address 0 when rstn=0 arrives mid-INIT or mid-RUN.

Verification (IDX_W=4, CTR_W=2, GHR_W=4, MODE=2)
REQ-029 SHALL cover: rstn=0 for 2 cycles then 1 -> ready=0 for 16 cycles then 1; a request to any pc then returns pred_ctr_b=1, pred_ctr_g=1, pred_sel=1, pred=0.
REQ-030 SHALL cover saturation: update with upd_ctr_b=1, actual=1 -> entry reads 2; upd_ctr_b=3, actual=1 -> 3; upd_ctr_b=0, actual=0 -> 0.
REQ-031 SHALL cover the chooser: upd_ctr_b=1, upd_ctr_g=2, upd_sel=1, actual=1 -> chooser reads 2; upd_ctr_b=2, upd_ctr_g=2 -> chooser unchanged.
REQ-032 SHALL cover the GHR: from GHR=0, three updates with actual=1,1,0 -> GHR=0b0110; a request with pc_idx=0b0101 -> pred_idx_g=0b0011, pred_idx_b=0b0101.
REQ-033 SHALL cover collision: request and update to the same index in the same cycle (old ctr 1, actual=1) -> pred_ctr_b=1; the next request to that index -> pred_ctr_b=2.
REQ-034 SHALL cover reset mid-INIT: rstn=0 at sweep address 5 -> after rstn returns to 1, ready stays 0 for a full 16 cycles and every entry reads its init value.

Source files
------------

// File: rtl/rip_tournament_predictor.sv
// Tournament branch predictor: bimodal + gshare counter tables with a 2-bit chooser,
// registered single-cycle prediction and a one-entry-per-cycle table initialisation sweep.
module rip_tournament_predictor #(
  parameter int IDX_W  = 10,
  parameter int CTR_W  = 2,
  parameter int GHR_W  = IDX_W,
  parameter int PC_LSB = 2,
  parameter int MODE   = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  input  logic [31:0]      pc,
  output logic             ready,
  output logic             pred_valid,
  output logic             pred,
  output logic [IDX_W-1:0] pred_idx_b,
  output logic [IDX_W-1:0] pred_idx_g,
  output logic [CTR_W-1:0] pred_ctr_b,
  output logic [CTR_W-1:0] pred_ctr_g,
  output logic [1:0]       pred_sel,
  input  logic             update,
  input  logic [IDX_W-1:0] upd_idx_b,
  input  logic [IDX_W-1:0] upd_idx_g,
  input  logic [CTR_W-1:0] upd_ctr_b,
  input  logic [CTR_W-1:0] upd_ctr_g,
  input  logic [1:0]       upd_sel,
  input  logic             actual
);

  // state | meaning
  // INIT  | sweeping every table entry to its weak initial value, one per cycle
  // RUN   | tables valid, serving predictions and updates
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [1:0]       SEL_INIT = 2'd1;

  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
    if (up) return (&c) ? c : c + 1'b1;
    else    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic [CTR_W-1:0] bim_mem [DEPTH];
  logic [CTR_W-1:0] gsh_mem [DEPTH];
  logic [1:0]       sel_mem [DEPTH];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;

  logic             pred_valid_q, pred_valid_d;
  logic [IDX_W-1:0] pred_idx_b_q, pred_idx_b_d;
  logic [IDX_W-1:0] pred_idx_g_q, pred_idx_g_d;
  logic [CTR_W-1:0] pred_ctr_b_q, pred_ctr_b_d;
  logic [CTR_W-1:0] pred_ctr_g_q, pred_ctr_g_d;
  logic [1:0]       pred_sel_q, pred_sel_d;

  logic             run;
  logic             req_fire;
  logic             upd_fire;
  logic [IDX_W-1:0] rd_idx_b;
  logic [IDX_W-1:0] rd_idx_g;
  logic             pred_int;
  logic             unused_pc;

  logic             we_b, we_g, we_s;
  logic [IDX_W-1:0] wa_b, wa_g, wa_s;
  logic [CTR_W-1:0] wd_b, wd_g;
  logic [1:0]       wd_s;

  assign run       = (state_q == ST_RUN);
  assign req_fire  = req_valid & run;
  assign upd_fire  = update & run;
  assign rd_idx_b  = pc[PC_LSB +: IDX_W];
  // Request uses the pre-shift history even when an update shifts it this cycle.
  assign rd_idx_g  = pc[PC_LSB +: IDX_W] ^ IDX_W'(ghr_q);
  assign unused_pc = ^pc;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ghr_d   = ghr_q;
    case (state_q)
      ST_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (&sweep_q) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (upd_fire && MODE != 0) ghr_d = GHR_W'({ghr_q, actual});
  end

  always_comb begin
    we_b = 1'b0;
    we_g = 1'b0;
    we_s = 1'b0;
    wa_b = upd_idx_b;
    wa_g = upd_idx_g;
    wa_s = upd_idx_b;
    wd_b = ctr_step(upd_ctr_b, actual);
    wd_g = ctr_step(upd_ctr_g, actual);
    wd_s = upd_sel;
    if (!rstn) begin
      we_b = 1'b0;
    end else if (state_q == ST_INIT) begin
      we_b = 1'b1;
      we_g = 1'b1;
      we_s = 1'b1;
      wa_b = sweep_q;
      wa_g = sweep_q;
      wa_s = sweep_q;
      wd_b = CTR_INIT;
      wd_g = CTR_INIT;
      wd_s = SEL_INIT;
    end else if (upd_fire) begin
      we_b = (MODE != 1);
      we_g = (MODE != 0);
      // Chooser only learns when the two components disagreed.
      if (MODE == 2 && (upd_ctr_b[CTR_W-1] != upd_ctr_g[CTR_W-1])) begin
        we_s = 1'b1;
        if (upd_ctr_g[CTR_W-1] == actual) wd_s = (upd_sel == 2'd3) ? upd_sel : upd_sel + 2'd1;
        else                              wd_s = (upd_sel == 2'd0) ? upd_sel : upd_sel - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we_b) bim_mem[wa_b] <= wd_b;
    if (we_g) gsh_mem[wa_g] <= wd_g;
    if (we_s) sel_mem[wa_s] <= wd_s;
  end

  always_comb begin
    pred_valid_d = req_fire;
    pred_idx_b_d = pred_idx_b_q;
    pred_idx_g_d = pred_idx_g_q;
    pred_ctr_b_d = pred_ctr_b_q;
    pred_ctr_g_d = pred_ctr_g_q;
    pred_sel_d   = pred_sel_q;
    if (req_fire) begin
      pred_idx_b_d = rd_idx_b;
      pred_idx_g_d = rd_idx_g;
      pred_ctr_b_d = bim_mem[rd_idx_b];
      pred_ctr_g_d = gsh_mem[rd_idx_g];
      pred_sel_d   = sel_mem[rd_idx_b];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      ghr_q        <= '0;
      pred_valid_q <= 1'b0;
      pred_idx_b_q <= '0;
      pred_idx_g_q <= '0;
      pred_ctr_b_q <= '0;
      pred_ctr_g_q <= '0;
      pred_sel_q   <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      ghr_q        <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_idx_b_q <= pred_idx_b_d;
      pred_idx_g_q <= pred_idx_g_d;
      pred_ctr_b_q <= pred_ctr_b_d;
      pred_ctr_g_q <= pred_ctr_g_d;
      pred_sel_q   <= pred_sel_d;
    end
  end

  always_comb begin
    case (MODE)
      0:       pred_int = pred_ctr_b_q[CTR_W-1];
      1:       pred_int = pred_ctr_g_q[CTR_W-1];
      default: pred_int = pred_sel_q[1] ? pred_ctr_g_q[CTR_W-1] : pred_ctr_b_q[CTR_W-1];
    endcase
  end

  // Outputs are forced low for the whole reset interval, not just after the first edge.
  assign ready      = rstn & run;
  assign pred_valid = rstn & pred_valid_q;
  assign pred       = rstn & pred_int;
  assign pred_idx_b = rstn ? pred_idx_b_q : '0;
  assign pred_idx_g = rstn ? pred_idx_g_q : '0;
  assign pred_ctr_b = rstn ? pred_ctr_b_q : '0;
  assign pred_ctr_g = rstn ? pred_ctr_g_q : '0;
  assign pred_sel   = rstn ? pred_sel_q   : '0;

endmodule

// File: tb/tb_rip_tournament_predictor.sv
// Directed bench for rip_tournament_predictor (IDX_W=4, CTR_W=2, GHR_W=4, MODE=2);
// hand-computed expectations queued at request time, compared when pred_valid appears.
module tb_rip_tournament_predictor;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic [31:0] pc;
  logic        ready;
  logic        pred_valid;
  logic        pred;
  logic [3:0]  pred_idx_b, pred_idx_g;
  logic [1:0]  pred_ctr_b, pred_ctr_g, pred_sel;
  logic        update;
  logic [3:0]  upd_idx_b, upd_idx_g;
  logic [1:0]  upd_ctr_b, upd_ctr_g, upd_sel;
  logic        actual;

  always #5 clk = ~clk;

  rip_tournament_predictor #(
    .IDX_W(4), .CTR_W(2), .GHR_W(4), .PC_LSB(2), .MODE(2)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .pc(pc), .ready(ready),
    .pred_valid(pred_valid), .pred(pred), .pred_idx_b(pred_idx_b), .pred_idx_g(pred_idx_g),
    .pred_ctr_b(pred_ctr_b), .pred_ctr_g(pred_ctr_g), .pred_sel(pred_sel),
    .update(update), .upd_idx_b(upd_idx_b), .upd_idx_g(upd_idx_g),
    .upd_ctr_b(upd_ctr_b), .upd_ctr_g(upd_ctr_g), .upd_sel(upd_sel), .actual(actual)
  );

  typedef struct {
    string      tag;
    logic [3:0] ib;
    logic [3:0] ig;
    logic [1:0] cb;
    logic [1:0] cg;
    logic [1:0] sel;
    logic       p;
  } exp_t;

  exp_t sb_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    assert (got === exp) checks_passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pred_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_pred_valid_queue_depth", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("%s_idx_b", e.tag), pred_idx_b, e.ib);
        chk($sformatf("%s_idx_g", e.tag), pred_idx_g, e.ig);
        chk($sformatf("%s_ctr_b", e.tag), pred_ctr_b, e.cb);
        chk($sformatf("%s_ctr_g", e.tag), pred_ctr_g, e.cg);
        chk($sformatf("%s_sel",   e.tag), pred_sel,   e.sel);
        chk($sformatf("%s_pred",  e.tag), pred,       e.p);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_valid = 1'b0;
    update    = 1'b0;
  endtask

  task automatic set_req(input logic [3:0] idx, input string tag, input logic [3:0] ig,
                         input logic [1:0] cb, input logic [1:0] cg, input logic [1:0] sel,
                         input logic p);
    logic [31:0] r;
    exp_t e;
    r      = $urandom;
    r[5:2] = idx;
    pc        = r;
    req_valid = 1'b1;
    e.tag = tag; e.ib = idx; e.ig = ig; e.cb = cb; e.cg = cg; e.sel = sel; e.p = p;
    sb_q.push_back(e);
  endtask

  task automatic set_upd(input logic [3:0] ib, input logic [3:0] ig, input logic [1:0] cb,
                         input logic [1:0] cg, input logic [1:0] sel, input logic act);
    update    = 1'b1;
    upd_idx_b = ib;
    upd_idx_g = ig;
    upd_ctr_b = cb;
    upd_ctr_g = cg;
    upd_sel   = sel;
    actual    = act;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rstn = 1'b0;
    pc   = '0;
    clr();
    set_upd(4'd0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    update = 1'b0;
    cyc();
    cyc();
    chk("rst_ready",      ready,      0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred",       pred,       0);
    chk("rst_idx_b",      pred_idx_b, 0);
    chk("rst_idx_g",      pred_idx_g, 0);
    chk("rst_ctr_b",      pred_ctr_b, 0);
    chk("rst_ctr_g",      pred_ctr_g, 0);
    chk("rst_sel",        pred_sel,   0);

    rstn = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin cyc(); n++; end
    chk("init_len", n, 16);

    set_req(4'd9,  "post_init_a", 4'd9,  2'd1, 2'd1, 2'd1, 1'b0); cyc(); clr();
    set_req(4'd15, "post_init_b", 4'd15, 2'd1, 2'd1, 2'd1, 1'b0); cyc(); clr();

    // Saturation on bimodal[3]; actuals 1,1,0 take GHR 0000 -> 0110.
    set_upd(4'd3, 4'd3,  2'd1, 2'd1, 2'd1, 1'b1); cyc(); clr();
    set_req(4'd3, "sat_up",  4'd2, 2'd2, 2'd1, 2'd1, 1'b1); cyc(); clr();
    set_upd(4'd3, 4'd12, 2'd3, 2'd3, 2'd1, 1'b1); cyc(); clr();
    set_req(4'd3, "sat_top", 4'd0, 2'd3, 2'd1, 2'd1, 1'b1); cyc(); clr();
    set_upd(4'd3, 4'd12, 2'd0, 2'd0, 2'd1, 1'b0); cyc(); clr();
    set_req(4'd3, "sat_bot", 4'd5, 2'd0, 2'd1, 2'd1, 1'b0); cyc(); clr();
    set_req(4'd5, "ghr",     4'd3, 2'd1, 2'd2, 2'd1, 1'b0); cyc(); clr();

    // Chooser: gshare right -> inc; agree -> hold; bimodal right -> dec.
    set_upd(4'd6, 4'd9,  2'd1, 2'd2, 2'd1, 1'b1); cyc(); clr();
    set_req(4'd6, "chooser_inc",  4'd11, 2'd2, 2'd1, 2'd2, 1'b0); cyc(); clr();
    set_upd(4'd6, 4'd9,  2'd2, 2'd2, 2'd2, 1'b0); cyc(); clr();
    set_req(4'd6, "chooser_hold", 4'd12, 2'd1, 2'd0, 2'd2, 1'b0); cyc(); clr();
    set_upd(4'd6, 4'd14, 2'd2, 2'd1, 2'd2, 1'b1); cyc(); clr();
    set_req(4'd6, "chooser_dec",  4'd3,  2'd3, 2'd2, 2'd1, 1'b1); cyc(); clr();

    // Same-cycle request and update to index 10: old value returned, GHR pre-shift used.
    set_upd(4'd10, 4'd10, 2'd1, 2'd1, 2'd1, 1'b1);
    set_req(4'd10, "collide_same", 4'd15, 2'd1, 2'd1, 2'd1, 1'b0); cyc(); clr();
    set_req(4'd10, "collide_next", 4'd1,  2'd2, 2'd1, 2'd1, 1'b1); cyc(); clr();
    cyc();
    cyc();
    chk("idle_pred_valid", pred_valid, 0);

    // Reset mid-INIT at sweep address 5, with traffic held during INIT.
    rstn = 1'b0;
    cyc();
    chk("rst2_ready",      ready,      0);
    chk("rst2_pred_valid", pred_valid, 0);
    rstn = 1'b1;
    repeat (5) cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    req_valid = 1'b1;
    pc = 32'h0000_0008;
    set_upd(4'd2, 4'd2, 2'd1, 2'd1, 2'd1, 1'b1);
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      if (n == 8) clr();
      cyc();
      n++;
    end
    chk("reinit_len", n, 16);
    clr();
    for (int i = 0; i < 16; i++) begin
      set_req(i[3:0], $sformatf("reinit%0d", i), i[3:0], 2'd1, 2'd1, 2'd1, 1'b0);
      cyc();
    end
    clr();
    cyc();
    cyc();
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
